core_lsu: RTL

Parametrised load/store unit for the memory stage of the pipelined core. It computes the effective address and checks alignment. It generates byte strobes and lane-shifted write data, and drives a valid/ready data-memory port through a small FSM. It returns sign- or zero-extended load data with one response pulse per request. It replaces the single-cycle strobe logic with a stallable, error-reporting, width-generic unit.

---
 rtl/core_lsu_pkg.sv | 36 +++
 rtl/core_lsu_align.sv | 79 +++++++
 rtl/core_lsu.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/core_lsu_pkg.sv
// Shared LSU definitions: FUNCT3 access codes, FSM state encoding and access sizes.
// Latency: none, declarations only.
// Backpressure: not applicable.
package core_lsu_pkg;

  // Load FUNCT3 codes
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LD  = 3'b011;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_LWU = 3'b110;

  // Store FUNCT3 codes
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;
  localparam logic [2:0] FUNCT3_SD  = 3'b011;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_t;

  // Access size is encoded in the low two FUNCT3 bits
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_t;

endpackage

// File: rtl/core_lsu_align.sv
// Access legality, alignment check, byte strobes, write lane shift and load extract/extend.
// Latency: purely combinational.
// Backpressure: none; evaluated from whatever fields the caller presents.
module core_lsu_align
  import core_lsu_pkg::*;
#(
  parameter int DW = 32,
  localparam int NB = DW / 8,
  localparam int OB = $clog2(NB)
) (
  input  logic [2:0]    funct3,
  input  logic          isload,
  input  logic          isstore,
  input  logic [OB-1:0] ofs,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata,
  output logic          illegal,
  output logic          misalign,
  output logic [NB-1:0] strb,
  output logic [DW-1:0] wdata_sh,
  output logic [DW-1:0] rdata_ext
);

  localparam bit HAS_D = (DW == 64);

  lsu_size_t     size;
  logic          sx;
  logic [NB-1:0] size_mask;
  logic [DW-1:0] lane;

  assign size = lsu_size_t'(funct3[1:0]);
  assign sx   = ~funct3[2];

  // Legal op flags and FUNCT3 for this bus width
  always_comb begin
    illegal = 1'b1;
    if (isload && !isstore) begin
      case (funct3)
        FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU: illegal = 1'b0;
        FUNCT3_LD, FUNCT3_LWU: illegal = !HAS_D;
        default: illegal = 1'b1;
      endcase
    end else if (isstore && !isload) begin
      case (funct3)
        FUNCT3_SB, FUNCT3_SH, FUNCT3_SW: illegal = 1'b0;
        FUNCT3_SD: illegal = !HAS_D;
        default: illegal = 1'b1;
      endcase
    end
  end

  // Natural alignment per size, plus the unshifted byte-enable mask
  always_comb begin
    misalign  = 1'b0;
    size_mask = NB'(1);
    case (size)
      SZ_B: begin misalign = 1'b0;       size_mask = NB'(1);     end
      SZ_H: begin misalign = ofs[0];     size_mask = NB'(3);     end
      SZ_W: begin misalign = |ofs[1:0];  size_mask = NB'(4'hF);  end
      default: begin misalign = |ofs;    size_mask = NB'(8'hFF); end
    endcase
  end

  assign strb     = size_mask << ofs;
  assign wdata_sh = wdata << {ofs, 3'b000};
  assign lane     = rdata >> {ofs, 3'b000};

  // Truncate the addressed lane to the access size and extend to DW
  always_comb begin
    rdata_ext = lane;
    case (size)
      SZ_B: begin rdata_ext = {DW{sx & lane[7]}};  rdata_ext[7:0]  = lane[7:0];  end
      SZ_H: begin rdata_ext = {DW{sx & lane[15]}}; rdata_ext[15:0] = lane[15:0]; end
      SZ_W: begin rdata_ext = {DW{sx & lane[31]}}; rdata_ext[31:0] = lane[31:0]; end
      default: rdata_ext = lane;
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// Memory-stage load/store unit: EA, alignment/legality, strobes, dmem valid/ready FSM, load extend.
// Latency: error rsp 1 cycle after accept, store 2, load 3, plus one per dmem stall cycle.
// Backpressure: REQ_READY low from accept until the cycle after RSP_VALID; DMEM outputs hold while DMEM_READY low.
module core_lsu
  import core_lsu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic            CLK,
  input  logic            NRST,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic            ISLOAD,
  input  logic            ISSTORE,
  input  logic [2:0]      FUNCT3,
  input  logic [AW-1:0]   BASE,
  input  logic [AW-1:0]   IMM,
  input  logic [DW-1:0]   WDATA,
  output logic            DMEM_VALID,
  input  logic            DMEM_READY,
  output logic            DMEM_WE,
  output logic [AW-1:0]   DMEM_ADDR,
  output logic [DW/8-1:0] DMEM_STRB,
  output logic [DW-1:0]   DMEM_WDATA,
  input  logic            DMEM_RVALID,
  input  logic [DW-1:0]   DMEM_RDATA,
  output logic            RSP_VALID,
  output logic [DW-1:0]   RSP_DATA,
  output logic            ERR_MISALIGN,
  output logic            ERR_ILLEGAL,
  output logic [AW-1:0]   ERR_ADDR
);

  localparam int NB = DW / 8;
  localparam int OB = $clog2(NB);

  lsu_state_t    state;
  logic [2:0]    f3_q;
  logic [OB-1:0] ofs_q;
  logic [AW-1:0] ea;
  logic          idle;
  logic [2:0]    a_f3;
  logic          a_ld;
  logic          a_st;
  logic [OB-1:0] a_ofs;
  logic          illegal;
  logic          misalign;
  logic [NB-1:0] strb;
  logic [DW-1:0] wdata_sh;
  logic [DW-1:0] rdata_ext;

  assign ea   = BASE + IMM;
  assign idle = (state == LSU_IDLE);

  // One align instance: live request fields while idle, latched fields afterwards for load extraction
  assign a_f3  = idle ? FUNCT3 : f3_q;
  assign a_ld  = idle ? ISLOAD : 1'b1;
  assign a_st  = idle ? ISSTORE : 1'b0;
  assign a_ofs = idle ? ea[OB-1:0] : ofs_q;

  core_lsu_align #(.DW(DW)) u_align (
    .funct3    (a_f3),
    .isload    (a_ld),
    .isstore   (a_st),
    .ofs       (a_ofs),
    .wdata     (WDATA),
    .rdata     (DMEM_RDATA),
    .illegal   (illegal),
    .misalign  (misalign),
    .strb      (strb),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  // Request FSM with registered handshake, memory and response outputs
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state        <= LSU_IDLE;
      f3_q         <= '0;
      ofs_q        <= '0;
      REQ_READY    <= 1'b1;
      DMEM_VALID   <= 1'b0;
      DMEM_WE      <= 1'b0;
      DMEM_ADDR    <= '0;
      DMEM_STRB    <= '0;
      DMEM_WDATA   <= '0;
      RSP_VALID    <= 1'b0;
      RSP_DATA     <= '0;
      ERR_MISALIGN <= 1'b0;
      ERR_ILLEGAL  <= 1'b0;
      ERR_ADDR     <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (REQ_VALID) begin
            f3_q      <= FUNCT3;
            ofs_q     <= ea[OB-1:0];
            REQ_READY <= 1'b0;
            if (illegal || misalign) begin
              // Faulting request: respond directly, never touch memory
              state        <= LSU_RESP;
              RSP_VALID    <= 1'b1;
              ERR_ILLEGAL  <= illegal;
              ERR_MISALIGN <= ~illegal;
              ERR_ADDR     <= ea;
            end else begin
              state      <= LSU_REQ;
              DMEM_VALID <= 1'b1;
              DMEM_WE    <= ISSTORE;
              DMEM_ADDR  <= {ea[AW-1:OB], {OB{1'b0}}};
              DMEM_STRB  <= strb;
              DMEM_WDATA <= ISSTORE ? wdata_sh : '0;
            end
          end
        end
        LSU_REQ: begin
          if (DMEM_READY) begin
            DMEM_VALID <= 1'b0;
            if (DMEM_WE) begin
              state     <= LSU_RESP;
              RSP_VALID <= 1'b1;
            end else begin
              state <= LSU_WAIT;
            end
          end
        end
        LSU_WAIT: begin
          if (DMEM_RVALID) begin
            state     <= LSU_RESP;
            RSP_VALID <= 1'b1;
            RSP_DATA  <= rdata_ext;
          end
        end
        LSU_RESP: begin
          state        <= LSU_IDLE;
          REQ_READY    <= 1'b1;
          RSP_VALID    <= 1'b0;
          RSP_DATA     <= '0;
          ERR_MISALIGN <= 1'b0;
          ERR_ILLEGAL  <= 1'b0;
          ERR_ADDR     <= '0;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule
